// File: rtl/pipelined_ram.sv
// pipelined_ram: dual-port unified instruction/data memory with stallable registered read pipelines.
// Optional feature macro RAM_WRITE_FORWARD_EN: forward same-edge data-port writes to instruction reads.
module pipelined_ram_pipe #(
    parameter int W = 32,
    parameter int L = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_err,
    input  logic         rsp_ready,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err,
    output logic         req_ready
);
    logic [L-1:0] valid;
    logic [L-1:0] err;
    logic [W-1:0] data [L];

    assign rsp_valid = valid[L-1];
    assign rsp_data  = data[L-1];
    assign rsp_err   = err[L-1];
    // The whole pipe freezes while the head response is refused; there is no skid entry.
    assign req_ready = ~(rsp_valid & ~rsp_ready);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
            err   <= '0;
            for (int k = 0; k < L; k++) data[k] <= '0;
        end else if (req_ready) begin
            valid[0] <= load;
            err[0]   <= load & load_err;
            data[0]  <= load ? load_data : '0;
            for (int k = 1; k < L; k++) begin
                valid[k] <= valid[k-1];
                err[k]   <= err[k-1];
                data[k]  <= data[k-1];
            end
        end
    end
endmodule

module pipelined_ram #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int DEPTH        = 1 << (ADDR_WIDTH - 2),
    parameter int READ_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    i_req_valid,
    output logic                    i_req_ready,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    output logic                    i_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   i_rsp_data,
    output logic                    i_rsp_err,
    input  logic                    d_req_valid,
    output logic                    d_req_ready,
    input  logic                    d_req_we,
    input  logic [ADDR_WIDTH-1:0]   d_req_addr,
    input  logic [DATA_WIDTH/8-1:0] d_req_wstrb,
    input  logic [DATA_WIDTH-1:0]   d_req_wdata,
    output logic                    d_rsp_valid,
    input  logic                    d_rsp_ready,
    output logic [DATA_WIDTH-1:0]   d_rsp_data,
    output logic                    d_rsp_err
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int MW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] i_word, d_word;
    logic [MW-1:0]         i_idx, d_idx;
    logic                  i_ok, d_ok, i_acc, d_acc, d_wr;
    logic [DATA_WIDTH-1:0] i_rd, d_rd;

    assign i_word = i_req_addr >> LSB;
    assign d_word = d_req_addr >> LSB;
    assign i_idx  = i_word[MW-1:0];
    assign d_idx  = d_word[MW-1:0];
    assign i_ok   = ((i_req_addr % ADDR_WIDTH'(STRB_W)) == '0) && ({1'b0, i_word} < LIMIT);
    assign d_ok   = ((d_req_addr % ADDR_WIDTH'(STRB_W)) == '0) && ({1'b0, d_word} < LIMIT);
    assign i_acc  = i_req_valid & i_req_ready;
    assign d_acc  = d_req_valid & d_req_ready;
    assign d_wr   = d_acc & d_req_we & d_ok;
    assign d_rd   = mem[d_idx];

`ifdef RAM_WRITE_FORWARD_EN
    logic [DATA_WIDTH-1:0] d_merged;
    always_comb begin
        d_merged = d_rd;
        for (int b = 0; b < STRB_W; b++)
            if (d_req_wstrb[b]) d_merged[8*b +: 8] = d_req_wdata[8*b +: 8];
    end
    assign i_rd = (d_wr && d_idx == i_idx) ? d_merged : mem[i_idx];
`else
    // Non-blocking array update makes a same-edge fetch see the pre-write word.
    assign i_rd = mem[i_idx];
`endif

    always_ff @(posedge clock) begin
        for (int b = 0; b < STRB_W; b++)
            if (d_wr && d_req_wstrb[b]) mem[d_idx][8*b +: 8] <= d_req_wdata[8*b +: 8];
    end

    pipelined_ram_pipe #(.W(DATA_WIDTH), .L(READ_LATENCY)) u_i_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (i_acc),
        .load_data (i_ok ? i_rd : '0),
        .load_err  (~i_ok),
        .rsp_ready (i_rsp_ready),
        .rsp_valid (i_rsp_valid),
        .rsp_data  (i_rsp_data),
        .rsp_err   (i_rsp_err),
        .req_ready (i_req_ready)
    );

    pipelined_ram_pipe #(.W(DATA_WIDTH), .L(READ_LATENCY)) u_d_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (d_acc),
        .load_data ((d_ok && !d_req_we) ? d_rd : '0),
        .load_err  (~d_ok),
        .rsp_ready (d_rsp_ready),
        .rsp_valid (d_rsp_valid),
        .rsp_data  (d_rsp_data),
        .rsp_err   (d_rsp_err),
        .req_ready (d_req_ready)
    );
endmodule

// File: tb/tb_pipelined_ram.sv
// tb_pipelined_ram: randomized and directed checks of pipelined_ram against a word-array reference model.
module tb_pipelined_ram;
    localparam int DEPTH = 100;
    localparam int RL    = 2;
`ifdef RAM_WRITE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } rsp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_rsp_err;
    logic [15:0] i_req_addr;
    logic [31:0] i_rsp_data;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [15:0] d_req_addr;
    logic [3:0]  d_req_wstrb;
    logic [31:0] d_req_wdata, d_rsp_data;
    logic [31:0] model [DEPTH];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    pipelined_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .clock(clock), .reset_n(reset_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) old[8*b +: 8] = wd[8*b +: 8];
        return old;
    endfunction

    function automatic logic addr_err(input logic [15:0] a);
        return a[1:0] != 2'b00 || int'(a >> 2) >= DEPTH;
    endfunction

    function automatic logic [15:0] rand_addr();
        int w = $urandom_range(0, DEPTH + 3);
        int o = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
        return 16'(w * 4 + o);
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic d_xact(input logic we, input logic [15:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                          output logic [31:0] data, output logic err, output int lat);
        int t = 0;
        d_req_valid = 1'b1; d_req_we = we; d_req_addr = addr; d_req_wstrb = strb; d_req_wdata = wd;
        d_rsp_ready = 1'b1;
        @(negedge clock);
        while (!d_req_ready && t < 10) begin @(negedge clock); t++; end
        tick;
        d_req_valid = 1'b0;
        lat = -1; data = 'x; err = 1'bx;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (d_rsp_valid) begin data = d_rsp_data; err = d_rsp_err; lat = c; break; end
        end
        tick;
    endtask

    task automatic i_xact(input logic [15:0] addr, output logic [31:0] data, output logic err, output int lat);
        int t = 0;
        i_req_valid = 1'b1; i_req_addr = addr; i_rsp_ready = 1'b1;
        @(negedge clock);
        while (!i_req_ready && t < 10) begin @(negedge clock); t++; end
        tick;
        i_req_valid = 1'b0;
        lat = -1; data = 'x; err = 1'bx;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (i_rsp_valid) begin data = i_rsp_data; err = i_rsp_err; lat = c; break; end
        end
        tick;
    endtask

    task automatic test_reset;
        d_rsp_ready = 1'b0; i_rsp_ready = 1'b0;
        repeat (2) @(negedge clock);
        n_vec++;
        if ({i_rsp_valid, d_rsp_valid, i_rsp_err, d_rsp_err} !== 4'b0000) begin
            n_err++; $display("FAIL reset_valid_err: got %b required 0000", {i_rsp_valid, d_rsp_valid, i_rsp_err, d_rsp_err});
        end
        n_vec++;
        if ({i_rsp_data, d_rsp_data} !== 64'h0) begin
            n_err++; $display("FAIL reset_data: got %h/%h required 0/0", i_rsp_data, d_rsp_data);
        end
        n_vec++;
        if ({i_req_ready, d_req_ready} !== 2'b11) begin
            n_err++; $display("FAIL reset_req_ready: got %b required 11", {i_req_ready, d_req_ready});
        end
        reset_n = 1'b1;
        tick;
    endtask

    task automatic test_fill;
        logic [31:0] r, wd;
        logic        e;
        int          lat;
        for (int w = 0; w < DEPTH; w++) begin
            wd = $urandom;
            d_xact(1'b1, 16'(w * 4), 4'hF, wd, r, e, lat);
            model[w] = wd;
            n_vec++;
            if (r !== 32'h0 || e !== 1'b0 || lat != RL) begin
                n_err++; $display("FAIL fill_write[%0d]: got data=%h err=%b lat=%0d required 0 0 %0d", w, r, e, lat, RL);
            end
        end
    endtask

    task automatic test_latency;
        logic [31:0] r;
        logic        e;
        int          lat;
        d_xact(1'b1, 16'h0010, 4'hF, 32'hDEADBEEF, r, e, lat);
        model[4] = 32'hDEADBEEF;
        n_vec++;
        if (r !== 32'h0 || e !== 1'b0 || lat != RL) begin
            n_err++; $display("FAIL latency_write: got data=%h err=%b lat=%0d required 0 0 %0d", r, e, lat, RL);
        end
        d_xact(1'b0, 16'h0010, 4'h0, 32'h0, r, e, lat);
        n_vec++;
        if (r !== 32'hDEADBEEF || e !== 1'b0 || lat != RL) begin
            n_err++; $display("FAIL latency_read: got data=%h err=%b lat=%0d required deadbeef 0 %0d", r, e, lat, RL);
        end
    endtask

    task automatic test_strobe;
        logic [31:0] r;
        logic        e;
        int          lat;
        d_xact(1'b1, 16'h0010, 4'b0010, 32'h0000AA00, r, e, lat);
        model[4] = 32'hDEADAAEF;
        d_xact(1'b0, 16'h0010, 4'h0, 32'h0, r, e, lat);
        n_vec++;
        if (r !== 32'hDEADAAEF || e !== 1'b0) begin
            n_err++; $display("FAIL strobe_merge: got %h err=%b required deadaaef 0", r, e);
        end
    endtask

    task automatic test_errors;
        logic [31:0] r;
        logic        e;
        int          lat;
        i_xact(16'h0006, r, e, lat);
        n_vec++;
        if (r !== 32'h0 || e !== 1'b1 || lat != RL) begin
            n_err++; $display("FAIL i_misaligned: got data=%h err=%b lat=%0d required 0 1 %0d", r, e, lat, RL);
        end
        i_xact(16'h0190, r, e, lat);
        n_vec++;
        if (r !== 32'h0 || e !== 1'b1) begin
            n_err++; $display("FAIL i_out_of_range: got data=%h err=%b required 0 1", r, e);
        end
        d_xact(1'b1, 16'h0190, 4'hF, 32'h55555555, r, e, lat);
        n_vec++;
        if (r !== 32'h0 || e !== 1'b1) begin
            n_err++; $display("FAIL d_write_out_of_range: got data=%h err=%b required 0 1", r, e);
        end
        d_xact(1'b1, 16'h0011, 4'hF, 32'hFFFFFFFF, r, e, lat);
        n_vec++;
        if (r !== 32'h0 || e !== 1'b1) begin
            n_err++; $display("FAIL d_write_misaligned: got data=%h err=%b required 0 1", r, e);
        end
        d_xact(1'b0, 16'h0010, 4'h0, 32'h0, r, e, lat);
        n_vec++;
        if (r !== model[4] || e !== 1'b0) begin
            n_err++; $display("FAIL err_write_no_effect: got %h err=%b required %h 0", r, e, model[4]);
        end
        d_xact(1'b0, 16'h0192, 4'h0, 32'h0, r, e, lat);
        n_vec++;
        if (r !== 32'h0 || e !== 1'b1) begin
            n_err++; $display("FAIL d_read_bad: got data=%h err=%b required 0 1", r, e);
        end
        d_xact(1'b1, 16'h018C, 4'hF, 32'hA5A5C3C3, r, e, lat);
        model[DEPTH-1] = 32'hA5A5C3C3;
        i_xact(16'h018C, r, e, lat);
        n_vec++;
        if (r !== 32'hA5A5C3C3 || e !== 1'b0) begin
            n_err++; $display("FAIL last_word: got data=%h err=%b required a5a5c3c3 0", r, e);
        end
    endtask

    task automatic test_collision;
        logic [31:0] r, exp;
        logic        e;
        int          lat;
        d_xact(1'b1, 16'h0020, 4'hF, 32'h0, r, e, lat);
        model[8] = 32'h0;
        i_req_valid = 1'b1; i_req_addr = 16'h0020; i_rsp_ready = 1'b1;
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 16'h0020; d_req_wstrb = 4'hF;
        d_req_wdata = 32'h12345678; d_rsp_ready = 1'b1;
        tick;
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        exp = FWD ? 32'h12345678 : model[8];
        model[8] = 32'h12345678;
        lat = -1; r = 'x;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (i_rsp_valid) begin r = i_rsp_data; lat = c; break; end
        end
        tick;
        n_vec++;
        if (r !== exp || lat != RL) begin
            n_err++; $display("FAIL collision_i: got data=%h lat=%0d required %h %0d", r, lat, exp, RL);
        end
        repeat (2) tick;
        d_xact(1'b0, 16'h0020, 4'h0, 32'h0, r, e, lat);
        n_vec++;
        if (r !== 32'h12345678 || e !== 1'b0) begin
            n_err++; $display("FAIL collision_d_after: got data=%h err=%b required 12345678 0", r, e);
        end
    endtask

    task automatic test_stall;
        logic [15:0] a [3] = '{16'h0010, 16'h0020, 16'h0078};
        logic [31:0] e [3];
        int          sent = 0;
        int          got = 0;
        int          last = -1;
        e[0] = model[4]; e[1] = model[8]; e[2] = model[30];
        i_rsp_ready = 1'b0;
        for (int c = 0; c < 15; c++) begin
            d_req_valid = sent < 3; d_req_we = 1'b0; d_req_addr = a[(sent < 3) ? sent : 0];
            d_rsp_ready = c >= 6;
            @(negedge clock);
            if (c >= 2 && c <= 5) begin
                n_vec++;
                if ({d_req_ready, d_rsp_valid, i_req_ready, d_rsp_data} !== {1'b0, 1'b1, 1'b1, e[0]}) begin
                    n_err++; $display("FAIL stall_hold c%0d: got ready=%b valid=%b i_ready=%b data=%h required 0 1 1 %h",
                                      c, d_req_ready, d_rsp_valid, i_req_ready, d_rsp_data, e[0]);
                end
            end
            if (d_rsp_valid && d_rsp_ready) begin
                n_vec++;
                if (got >= 3 || d_rsp_data !== e[(got < 3) ? got : 0] || d_rsp_err !== 1'b0 || (got > 0 && c != last + 1)) begin
                    n_err++; $display("FAIL stall_release rsp%0d c%0d: got %h err=%b required %h 0 in cycle %0d",
                                      got, c, d_rsp_data, d_rsp_err, e[(got < 3) ? got : 0], last + 1);
                end
                last = c; got++;
            end
            if (d_req_valid && d_req_ready) sent++;
            tick;
        end
        d_req_valid = 1'b0;
        n_vec++;
        if (got != 3) begin
            n_err++; $display("FAIL stall_count: got %0d responses required 3", got);
        end
    endtask

    task automatic test_random(input int cycles);
        rsp_t iq [$];
        rsp_t dq [$];
        rsp_t ie, de, prev_i, prev_d;
        bit   i_st = 1'b0;
        bit   d_st = 1'b0;
        bit   d_acc;
        int   w;
        for (int c = 0; c < cycles + 20; c++) begin
            i_req_valid = c < cycles && $urandom_range(0, 3) != 0;
            i_req_addr  = rand_addr();
            i_rsp_ready = c >= cycles || $urandom_range(0, 3) != 0;
            d_req_valid = c < cycles && $urandom_range(0, 3) != 0;
            d_req_we    = 1'($urandom_range(0, 1));
            d_req_addr  = ($urandom_range(0, 5) == 0) ? i_req_addr : rand_addr();
            d_req_wstrb = 4'($urandom);
            d_req_wdata = $urandom;
            d_rsp_ready = c >= cycles || $urandom_range(0, 3) != 0;
            @(negedge clock);
            if (i_st) begin
                n_vec++;
                if (i_rsp_valid !== 1'b1 || {i_rsp_data, i_rsp_err} !== prev_i) begin
                    n_err++; $display("FAIL i_stall_stable c%0d: got v=%b %h/%b required v=1 %h/%b",
                                      c, i_rsp_valid, i_rsp_data, i_rsp_err, prev_i.d, prev_i.e);
                end
            end
            if (d_st) begin
                n_vec++;
                if (d_rsp_valid !== 1'b1 || {d_rsp_data, d_rsp_err} !== prev_d) begin
                    n_err++; $display("FAIL d_stall_stable c%0d: got v=%b %h/%b required v=1 %h/%b",
                                      c, d_rsp_valid, d_rsp_data, d_rsp_err, prev_d.d, prev_d.e);
                end
            end
            n_vec++;
            if ({i_req_ready, d_req_ready} !== {!(i_rsp_valid && !i_rsp_ready), !(d_rsp_valid && !d_rsp_ready)}) begin
                n_err++; $display("FAIL req_ready c%0d: got %b required %b", c, {i_req_ready, d_req_ready},
                                  {!(i_rsp_valid && !i_rsp_ready), !(d_rsp_valid && !d_rsp_ready)});
            end
            if (i_rsp_valid && i_rsp_ready) begin
                n_vec++;
                if (iq.size() == 0) begin
                    n_err++; $display("FAIL i_rsp_unexpected c%0d: got %h required none", c, i_rsp_data);
                end else begin
                    ie = iq.pop_front();
                    if ({i_rsp_data, i_rsp_err} !== ie) begin
                        n_err++; $display("FAIL i_rsp c%0d: got %h/%b required %h/%b", c, i_rsp_data, i_rsp_err, ie.d, ie.e);
                    end
                end
            end
            if (d_rsp_valid && d_rsp_ready) begin
                n_vec++;
                if (dq.size() == 0) begin
                    n_err++; $display("FAIL d_rsp_unexpected c%0d: got %h required none", c, d_rsp_data);
                end else begin
                    de = dq.pop_front();
                    if ({d_rsp_data, d_rsp_err} !== de) begin
                        n_err++; $display("FAIL d_rsp c%0d: got %h/%b required %h/%b", c, d_rsp_data, d_rsp_err, de.d, de.e);
                    end
                end
            end
            i_st = i_rsp_valid && !i_rsp_ready; prev_i = {i_rsp_data, i_rsp_err};
            d_st = d_rsp_valid && !d_rsp_ready; prev_d = {d_rsp_data, d_rsp_err};
            d_acc = d_req_valid && d_req_ready;
            if (i_req_valid && i_req_ready) begin
                w = int'(i_req_addr >> 2);
                ie.e = addr_err(i_req_addr);
                ie.d = ie.e ? 32'h0 : model[w];
                if (FWD && !ie.e && d_acc && d_req_we && !addr_err(d_req_addr) && int'(d_req_addr >> 2) == w)
                    ie.d = merge(model[w], d_req_wdata, d_req_wstrb);
                iq.push_back(ie);
            end
            if (d_acc) begin
                w = int'(d_req_addr >> 2);
                de.e = addr_err(d_req_addr);
                de.d = (de.e || d_req_we) ? 32'h0 : model[w];
                if (!de.e && d_req_we) model[w] = merge(model[w], d_req_wdata, d_req_wstrb);
                dq.push_back(de);
            end
            tick;
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        n_vec++;
        if (iq.size() != 0 || dq.size() != 0) begin
            n_err++; $display("FAIL random_drain: got %0d/%0d outstanding required 0/0", iq.size(), dq.size());
        end
    endtask

    task automatic test_reset_flight;
        i_rsp_ready = 1'b0; d_rsp_ready = 1'b0;
        i_req_valid = 1'b1; i_req_addr = 16'h0010;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 16'h0014;
        repeat (2) tick;
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clock);
        n_vec++;
        if ({i_rsp_valid, d_rsp_valid} !== 2'b11) begin
            n_err++; $display("FAIL flight_setup: got %b required 11", {i_rsp_valid, d_rsp_valid});
        end
        #1 reset_n = 1'b0;
        #1;
        n_vec++;
        if ({i_rsp_valid, d_rsp_valid, i_rsp_err, d_rsp_err, i_req_ready, d_req_ready} !== 6'b000011 ||
            {i_rsp_data, d_rsp_data} !== 64'h0) begin
            n_err++; $display("FAIL flight_reset: got %b %h/%h required 000011 0/0",
                              {i_rsp_valid, d_rsp_valid, i_rsp_err, d_rsp_err, i_req_ready, d_req_ready}, i_rsp_data, d_rsp_data);
        end
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        i_rsp_ready = 1'b1; d_rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            n_vec++;
            if ({i_rsp_valid, d_rsp_valid} !== 2'b00) begin
                n_err++; $display("FAIL flight_stale c%0d: got %b required 00", c, {i_rsp_valid, d_rsp_valid});
            end
        end
    endtask

    initial begin
        i_req_valid = 1'b0; i_req_addr = '0; i_rsp_ready = 1'b0;
        d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wstrb = '0; d_req_wdata = '0; d_rsp_ready = 1'b0;
        test_reset;
        test_fill;
        test_latency;
        test_strobe;
        test_errors;
        test_collision;
        test_stall;
        test_random(400);
        test_reset_flight;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
